// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: fixed-latency data-memory controller for the core data port.
// Drives a single-port synchronous SRAM and decodes the STDOUT/EXIT addresses.
//
// Ports:
//   clk, rst (async active-low)
//   MREQ/WRITE/SIZE/DAD/ddt_i : core request, captured once in IDLE
//   ddt_o/ddt_oe              : load data back to the core (valid in ACK)
//   ACKD_n                    : active-low acknowledge, one cycle
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : SRAM port
//   stdout_valid/stdout_char  : character output pulse
//   exit_req                  : sticky exit request
//   bus_err                   : error pulse in ACK
module dmem_bus_ctrl #(
    parameter int          LATENCY     = 2,
    parameter int          AW          = 21,
    parameter logic [31:0] DMEM_BASE   = 32'h0800_0000,
    parameter logic [31:0] STDOUT_ADDR = 32'hf000_0000,
    parameter logic [31:0] EXIT_ADDR   = 32'hff00_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MREQ,
    input  logic          WRITE,
    input  logic [1:0]    SIZE,
    input  logic [31:0]   DAD,
    input  logic [31:0]   ddt_i,
    output logic [31:0]   ddt_o,
    output logic          ddt_oe,
    output logic          ACKD_n,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          stdout_valid,
    output logic [7:0]    stdout_char,
    output logic          exit_req,
    output logic          bus_err
);

    localparam int CW = $clog2(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          wr_q, wr_d;
    logic          hit_q, hit_d;
    logic          err_q, err_d;
    logic          out_q, out_d;
    logic          ext_q, ext_d;
    logic [3:0]    we_q, we_d;
    logic          ackd_n_q, ackd_n_d;
    logic          mem_en_q, mem_en_d;
    logic [3:0]    mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          stdout_valid_q, stdout_valid_d;
    logic [7:0]    stdout_char_q, stdout_char_d;
    logic          exit_req_q, exit_req_d;
    logic          bus_err_q, bus_err_d;

    logic [1:0]    off_c;
    logic [32:0]   rel_c;
    logic          mis_c, inr_c, out_c, ext_c, hit_c, err_c;
    logic [3:0]    we_c;
    logic          ack_nxt;
    logic [31:0]   lane;

    // Request decode; special stores win over the SRAM range.
    always_comb begin
        off_c = DAD[1:0];
        rel_c = {1'b0, DAD} - {1'b0, DMEM_BASE};
        mis_c = (SIZE == 2'b00 && off_c != 2'd0)
             || (SIZE == 2'b01 && off_c == 2'd3);
        // bit 32 is the borrow: DAD below the base
        inr_c = !rel_c[32] && (rel_c < (33'd4 << AW));
        out_c = WRITE && (DAD == STDOUT_ADDR);
        ext_c = WRITE && (DAD == EXIT_ADDR);
        hit_c = !out_c && !ext_c && !mis_c && inr_c;
        err_c = !out_c && !ext_c && !hit_c;
        unique case (SIZE)
            2'b00:   we_c = 4'b1111;
            2'b01:   we_c = 4'b0011 << off_c;
            default: we_c = 4'b0001 << off_c;
        endcase
        if (!WRITE) we_c = 4'b0000;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        off_d         = off_q;
        size_d        = size_q;
        wr_d          = wr_q;
        hit_d         = hit_q;
        err_d         = err_q;
        out_d         = out_q;
        ext_d         = ext_q;
        we_d          = we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        stdout_char_d = stdout_char_q;
        unique case (state_q)
            S_IDLE: begin
                if (MREQ) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                    off_d   = off_c;
                    size_d  = SIZE;
                    wr_d    = WRITE;
                    hit_d   = hit_c;
                    err_d   = err_c;
                    out_d   = out_c;
                    ext_d   = ext_c;
                    we_d    = we_c;
                    if (hit_c) mem_addr_d = AW'(rel_c >> 2);
                    if (hit_c && WRITE) begin
                        mem_wdata_d = ddt_i << {off_c, 3'b000};
                    end
                    if (out_c) stdout_char_d = ddt_i[7:0];
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobe in the last WAIT cycle so read data lands in ACK.
        mem_en_d = hit_d && (state_d == S_WAIT) && (cnt_d == CW'(1));
        mem_we_d = mem_en_d ? we_d : 4'b0000;

        ack_nxt        = (state_d == S_ACK);
        ackd_n_d       = !ack_nxt;
        stdout_valid_d = ack_nxt && out_d;
        bus_err_d      = ack_nxt && err_d;
        exit_req_d     = exit_req_q || (ack_nxt && ext_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            off_q          <= '0;
            size_q         <= '0;
            wr_q           <= 1'b0;
            hit_q          <= 1'b0;
            err_q          <= 1'b0;
            out_q          <= 1'b0;
            ext_q          <= 1'b0;
            we_q           <= '0;
            ackd_n_q       <= 1'b1;
            mem_en_q       <= 1'b0;
            mem_we_q       <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            stdout_valid_q <= 1'b0;
            stdout_char_q  <= '0;
            exit_req_q     <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            off_q          <= off_d;
            size_q         <= size_d;
            wr_q           <= wr_d;
            hit_q          <= hit_d;
            err_q          <= err_d;
            out_q          <= out_d;
            ext_q          <= ext_d;
            we_q           <= we_d;
            ackd_n_q       <= ackd_n_d;
            mem_en_q       <= mem_en_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            stdout_valid_q <= stdout_valid_d;
            stdout_char_q  <= stdout_char_d;
            exit_req_q     <= exit_req_d;
            bus_err_q      <= bus_err_d;
        end
    end

    // Load return path is combinational from the SRAM output in ACK.
    always_comb begin
        lane   = mem_rdata >> {off_q, 3'b000};
        ddt_o  = '0;
        ddt_oe = 1'b0;
        if (state_q == S_ACK && !wr_q) begin
            ddt_oe = 1'b1;
            if (hit_q) begin
                unique case (size_q)
                    2'b00:   ddt_o = lane;
                    2'b01:   ddt_o = {16'h0000, lane[15:0]};
                    default: ddt_o = {24'h000000, lane[7:0]};
                endcase
            end
        end
    end

    assign ACKD_n       = ackd_n_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign stdout_valid = stdout_valid_q;
    assign stdout_char  = stdout_char_q;
    assign exit_req     = exit_req_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb_dmem_bus_ctrl: directed bench for dmem_bus_ctrl, LATENCY 2 and 4.
// Transaction-level model plus a per-cycle compare process.
module tb_dmem_bus_ctrl;

    localparam int          AW     = 21;
    localparam logic [31:0] BASE   = 32'h0800_0000;
    localparam logic [31:0] STDOUT = 32'hf000_0000;
    localparam logic [31:0] EXITA  = 32'hff00_0000;

    logic          clk;
    logic          rst;
    logic          mreq [2];
    logic          wr;
    logic [1:0]    sz;
    logic [31:0]   dad;
    logic [31:0]   ddt_i;
    logic [31:0]   ddt_o [2];
    logic          ddt_oe [2];
    logic          ackd_n [2];
    logic          mem_en [2];
    logic [3:0]    mem_we [2];
    logic [AW-1:0] mem_addr [2];
    logic [31:0]   mem_wdata [2];
    logic [31:0]   mem_rdata [2];
    logic          sv [2];
    logic [7:0]    sc [2];
    logic          ex [2];
    logic          be [2];

    dmem_bus_ctrl #(.LATENCY(2), .AW(AW)) u_a (
        .clk(clk), .rst(rst), .MREQ(mreq[0]), .WRITE(wr), .SIZE(sz),
        .DAD(dad), .ddt_i(ddt_i), .ddt_o(ddt_o[0]), .ddt_oe(ddt_oe[0]),
        .ACKD_n(ackd_n[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .stdout_valid(sv[0]),
        .stdout_char(sc[0]), .exit_req(ex[0]), .bus_err(be[0])
    );

    dmem_bus_ctrl #(.LATENCY(4), .AW(AW)) u_b (
        .clk(clk), .rst(rst), .MREQ(mreq[1]), .WRITE(wr), .SIZE(sz),
        .DAD(dad), .ddt_i(ddt_i), .ddt_o(ddt_o[1]), .ddt_oe(ddt_oe[1]),
        .ACKD_n(ackd_n[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .stdout_valid(sv[1]),
        .stdout_char(sc[1]), .exit_req(ex[1]), .bus_err(be[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM behind each DUT: read-first, data valid the cycle after mem_en.
    logic [31:0] sram [2][64];

    function automatic logic [31:0] merge(logic [31:0] o, logic [3:0] w,
                                          logic [31:0] d);
        logic [31:0] r;
        r = o;
        for (int l = 0; l < 4; l++) if (w[l]) r[8*l +: 8] = d[8*l +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_en[d]) begin
                mem_rdata[d] <= sram[d][mem_addr[d][5:0]];
                sram[d][mem_addr[d][5:0]] <=
                    merge(sram[d][mem_addr[d][5:0]], mem_we[d], mem_wdata[d]);
            end
        end
    end

    // Reference memory: byte-addressed, keyed by dut index and address.
    logic [7:0] refm [longint];

    function automatic longint rkey(int d, logic [31:0] a);
        return (longint'(d) << 40) | longint'(a);
    endfunction

    function automatic logic [7:0] rget(int d, logic [31:0] a);
        longint k;
        k = rkey(d, a);
        return refm.exists(k) ? refm[k] : 8'h00;
    endfunction

    int nvec;
    int nbad;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endfunction

    // Per-cycle expectations consumed by the compare process.
    logic          e_ack_n [2];
    logic          e_en [2];
    logic [3:0]    e_we [2];
    logic [AW-1:0] e_addr [2];
    logic [31:0]   e_wd [2];
    logic          e_chk_wd [2];
    logic          e_sv [2];
    logic [7:0]    e_sc [2];
    logic          e_exit [2];
    logic          e_err [2];
    logic          e_oe [2];
    logic [31:0]   e_do [2];
    logic          e_rst;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ackd_n%0d", d), 32'(ackd_n[d]), 32'(e_ack_n[d]));
            chk($sformatf("mem_en%0d", d), 32'(mem_en[d]), 32'(e_en[d]));
            chk($sformatf("stdout_valid%0d", d), 32'(sv[d]), 32'(e_sv[d]));
            chk($sformatf("exit_req%0d", d), 32'(ex[d]), 32'(e_exit[d]));
            chk($sformatf("bus_err%0d", d), 32'(be[d]), 32'(e_err[d]));
            chk($sformatf("ddt_oe%0d", d), 32'(ddt_oe[d]), 32'(e_oe[d]));
            chk($sformatf("ddt_o%0d", d), ddt_o[d], e_do[d]);
            if (e_en[d]) begin
                chk($sformatf("mem_addr%0d", d), 32'(mem_addr[d]),
                    32'(e_addr[d]));
                chk($sformatf("mem_we%0d", d), 32'(mem_we[d]), 32'(e_we[d]));
                if (e_chk_wd[d])
                    chk($sformatf("mem_wdata%0d", d), mem_wdata[d], e_wd[d]);
            end
            if (e_sv[d])
                chk($sformatf("stdout_char%0d", d), 32'(sc[d]), 32'(e_sc[d]));
            if (e_rst) begin
                chk($sformatf("rst_we%0d", d), 32'(mem_we[d]), 32'h0);
                chk($sformatf("rst_addr%0d", d), 32'(mem_addr[d]), 32'h0);
                chk($sformatf("rst_wdata%0d", d), mem_wdata[d], 32'h0);
                chk($sformatf("rst_char%0d", d), 32'(sc[d]), 32'h0);
            end
        end
    end

    task automatic set_idle(input int d);
        e_ack_n[d]  = 1'b1;
        e_en[d]     = 1'b0;
        e_we[d]     = 4'h0;
        e_addr[d]   = '0;
        e_wd[d]     = 32'h0;
        e_chk_wd[d] = 1'b0;
        e_sv[d]     = 1'b0;
        e_sc[d]     = 8'h00;
        e_err[d]    = 1'b0;
        e_oe[d]     = 1'b0;
        e_do[d]     = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mreq[0] = 1'b0;
            mreq[1] = 1'b0;
            set_idle(0);
            set_idle(1);
            @(posedge clk);
            #1;
        end
    endtask

    // Observations of the last access, for literal checks.
    int            r_ack;
    int            r_en;
    int            r_sv;
    int            r_err;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_we;
    logic [31:0]   r_wd;
    logic [31:0]   r_do;
    logic [7:0]    r_char;
    logic          r_exit;

    // One access on dut d, starting at cycle 0; returns at cycle LAT+1.
    task automatic access(input int d, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] dt,
                          input bit hold, input int rst_at);
        int          lat, o, n;
        bit          sp_out, sp_ex, mis, inr, hit, err, abrt;
        logic [3:0]  we;
        logic [31:0] rv;
        lat    = (d == 0) ? 2 : 4;
        o      = int'(a[1:0]);
        n      = (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : 1;
        sp_out = w && (a == STDOUT);
        sp_ex  = w && (a == EXITA);
        mis    = (s == 2'b00 && o != 0) || (s == 2'b01 && o == 3);
        inr    = longint'(a) >= longint'(BASE)
              && longint'(a) < longint'(BASE) + (longint'(4) << AW);
        hit    = !sp_out && !sp_ex && !mis && inr;
        err    = !sp_out && !sp_ex && !hit;
        we     = 4'h0;
        rv     = 32'h0;
        abrt   = 1'b0;
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                if (w) we[o+i] = 1'b1;
                else rv = rv | (32'(rget(d, a + 32'(i))) << (8 * i));
            end
        end
        r_ack = -1; r_en = 0; r_sv = 0; r_err = 0;
        r_addr = '0; r_we = 4'h0; r_wd = 32'h0; r_do = 32'h0;
        r_char = 8'h00; r_exit = 1'b0;
        mreq[d] = 1'b1; wr = w; sz = s; dad = a; ddt_i = dt;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0 && !hold) begin
                mreq[d] = 1'b0;
                dad     = $urandom;
                ddt_i   = $urandom;
                wr      = 1'($urandom);
                sz      = 2'($urandom);
            end
            if (k == rst_at) begin
                rst     = 1'b0;
                abrt    = 1'b1;
                mreq[d] = 1'b0;
            end
            set_idle(0);
            set_idle(1);
            if (abrt) begin
                e_rst     = 1'b1;
                e_exit[0] = 1'b0;
                e_exit[1] = 1'b0;
            end else begin
                e_ack_n[d]  = (k != lat);
                e_en[d]     = hit && (k == lat - 1);
                e_we[d]     = we;
                e_addr[d]   = AW'((a - BASE) >> 2);
                e_wd[d]     = dt << (8 * o);
                e_chk_wd[d] = w;
                e_sv[d]     = sp_out && (k == lat);
                e_sc[d]     = dt[7:0];
                e_err[d]    = err && (k == lat);
                e_oe[d]     = !w && (k == lat);
                e_do[d]     = (!w && k == lat) ? rv : 32'h0;
                if (sp_ex && k == lat) e_exit[d] = 1'b1;
            end
            @(negedge clk);
            if (!ackd_n[d] && r_ack < 0) r_ack = k;
            if (mem_en[d]) begin
                r_en++;
                r_addr = mem_addr[d];
                r_we   = mem_we[d];
                r_wd   = mem_wdata[d];
            end
            if (sv[d]) begin r_sv++; r_char = sc[d]; end
            if (be[d]) r_err++;
            if (k == lat) r_do = ddt_o[d];
            r_exit = ex[d];
            @(posedge clk);
            #1;
        end
        if (abrt) begin
            rst   = 1'b1;
            e_rst = 1'b0;
            set_idle(0);
            set_idle(1);
        end else if (hit && w) begin
            for (int i = 0; i < n; i++) refm[rkey(d, a + 32'(i))] = dt[8*i +: 8];
        end
        if (!hold) mreq[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        nvec = 0; nbad = 0;
        rst = 1'b0; mreq[0] = 1'b0; mreq[1] = 1'b0;
        wr = 1'b0; sz = 2'b00; dad = 32'h0; ddt_i = 32'h0;
        set_idle(0); set_idle(1);
        e_exit[0] = 1'b0; e_exit[1] = 1'b0;
        e_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        e_rst = 1'b0;
        idle(2);

        access(0, 1'b1, 2'b00, 32'h0800_0010, 32'hDEAD_BEEF, 0, -1);
        chk("sw_addr", 32'(r_addr), 32'd4);
        chk("sw_we", 32'(r_we), 32'hF);
        chk("sw_ack_cycle", 32'(r_ack), 32'd2);
        chk("sw_en_count", 32'(r_en), 32'd1);
        access(0, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 1, -1);
        chk("lw_data", r_do, 32'hDEAD_BEEF);
        access(0, 1'b1, 2'b10, 32'h0800_0011, 32'h0000_0055, 0, -1);
        chk("sb_we", 32'(r_we), 32'h2);
        chk("sb_wdata_b1", 32'(r_wd[15:8]), 32'h55);
        idle(1);
        access(0, 1'b0, 2'b10, 32'h0800_0011, 32'h0, 0, -1);
        chk("lb_data", r_do, 32'h0000_0055);
        access(0, 1'b0, 2'b01, 32'h0800_0012, 32'h0, 0, -1);
        chk("lh_data", r_do, 32'h0000_DEAD);
        access(0, 1'b1, 2'b01, 32'h0800_0011, 32'h0000_1234, 0, -1);
        chk("sh_mid_we", 32'(r_we), 32'h6);
        access(0, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 0, -1);
        chk("lw_after_sh", r_do, 32'hDE12_34EF);
        access(0, 1'b1, 2'b11, 32'h0800_0013, 32'h0000_00A5, 0, -1);
        access(0, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 0, -1);

        access(0, 1'b1, 2'b10, STDOUT, 32'h0000_0041, 0, -1);
        chk("stdout_char_lit", 32'(r_char), 32'h41);
        chk("stdout_pulses", 32'(r_sv), 32'd1);
        chk("stdout_no_en", 32'(r_en), 32'd0);
        chk("stdout_ack_cycle", 32'(r_ack), 32'd2);
        access(0, 1'b0, 2'b00, STDOUT, 32'h0, 0, -1);
        access(0, 1'b1, 2'b00, EXITA, 32'h0, 0, -1);
        chk("exit_in_ack", 32'(r_exit), 32'd1);
        idle(3);
        access(0, 1'b0, 2'b01, 32'h0800_0013, 32'h0, 0, -1);
        chk("lh_mis_err", 32'(r_err), 32'd1);
        chk("lh_mis_data", r_do, 32'h0);
        chk("lh_mis_no_en", 32'(r_en), 32'd0);
        access(0, 1'b1, 2'b00, 32'h0800_0012, 32'h1111_2222, 0, -1);
        access(0, 1'b1, 2'b00, 32'h087F_FFFC, 32'h0BAD_F00D, 0, -1);
        access(0, 1'b0, 2'b00, 32'h087F_FFFC, 32'h0, 0, -1);
        access(0, 1'b0, 2'b10, 32'h087F_FFFF, 32'h0, 0, -1);
        chk("lb_top_lane", r_do, 32'h0000_000B);
        access(0, 1'b0, 2'b00, 32'h0880_0000, 32'h0, 0, -1);
        access(0, 1'b0, 2'b00, 32'h07FF_FFFC, 32'h0, 0, -1);
        idle(1);

        access(1, 1'b1, 2'b00, 32'h0800_0020, 32'h1234_5678, 0, -1);
        chk("l4_ack_cycle", 32'(r_ack), 32'd4);
        access(1, 1'b0, 2'b00, 32'h0800_0020, 32'h0, 0, -1);
        chk("l4_lw", r_do, 32'h1234_5678);
        access(1, 1'b1, 2'b00, 32'h0800_0020, 32'hCAFE_F00D, 0, 2);
        chk("rst_no_en", 32'(r_en), 32'd0);
        chk("rst_no_ack", 32'(r_ack), 32'hFFFF_FFFF);
        idle(2);
        access(1, 1'b0, 2'b00, 32'h0800_0020, 32'h0, 0, -1);
        chk("rst_sram_kept", r_do, 32'h1234_5678);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
